// File: rtl/mux_arb_sel.sv
// rtl/mux_arb_sel.sv - N-channel selector/arbiter into a one-entry output register
// mode=0 passes the channel chosen by sel; mode=1 arbitrates round-robin from ptr+1.
module mux_arb_sel #(
  parameter int WIDTH = 32,
  parameter int SELW  = 2,
  localparam int NCH  = 2 ** SELW
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] inData,
  input  logic [NCH-1:0]       inValid,
  output logic [NCH-1:0]       inReady,
  output logic [WIDTH-1:0]     out,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [SELW-1:0]      outSel
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             can_accept;
  logic             req;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  idx;
  logic             transfer;

  assign can_accept = !out_valid_q || outReady;

  // Round-robin search visits ptr+1 .. ptr+NCH, so ptr itself is tried last.
  always_comb begin
    req   = 1'b0;
    grant = '0;
    idx   = '0;
    if (!mode) begin
      grant = sel;
      req   = inValid[sel];
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        idx = ptr_q + SELW'(k);
        if (!req && inValid[idx]) begin
          req   = 1'b1;
          grant = idx;
        end
      end
    end
  end

  assign transfer = req && can_accept && !Reset;

  always_comb begin
    inReady = '0;
    if (transfer) inReady[grant] = 1'b1;
  end

  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (transfer) begin
      out_d       = inData[grant*WIDTH +: WIDTH];
      out_sel_d   = grant;
      out_valid_d = 1'b1;
      if (mode) ptr_d = grant;
    end else if (out_valid_q && outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_q       <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out      = out_q;
  assign outSel   = out_sel_q;
  assign outValid = out_valid_q;

endmodule
